// File: rtl/spi_bitbang_master.sv
// Purpose : bit-banged SPI mode 0 master, MSB first; pops words from a FWFT source, returns captured MISO words.
// Latency : CS falls on the load edge, put 2W cycles after load; streaming period 2W+1 cycles per word.
// Backpress: source throttles via empty (checked only between words); put has no back-pressure, sink must take it.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   in, empty, get      first-word-fall-through source; get pops the word on in
//   out, put            last received word, one-cycle strobe when out is new
//   spi_cs_n, spi_clock, spi_mosi, spi_miso   SPI bus (SCLK idles low)
module spi_bitbang_master #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] in,
    output logic         get,
    input  logic         empty,
    output logic [W-1:0] out,
    output logic         put,
    output logic         spi_cs_n,
    output logic         spi_clock,
    output logic         spi_mosi,
    input  logic         spi_miso
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  tx;
    logic [W-1:0]  rx;
    logic [CW-1:0] cnt;
    logic          load;

    // MOSI comes straight off the shift register, so it only moves when tx
    // moves: at load, or on the HIGH->LOW edge that drops SCLK.
    assign spi_mosi = tx[W-1];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = empty ? IDLE : LOW;
            LOW:     state_nxt = HIGH;
            HIGH:    state_nxt = (cnt == '0) ? DONE : LOW;
            DONE:    state_nxt = empty ? IDLE : LOW;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        get  = 1'b0;
        put  = 1'b0;
        load = 1'b0;
        case (state)
            IDLE: begin
                get  = ~empty;
                load = ~empty;
            end
            DONE: begin
                // Pop of the next word and delivery of the finished one
                // share this cycle when streaming.
                get  = ~empty;
                load = ~empty;
                put  = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and SPI pin registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx        <= '0;
            rx        <= '0;
            cnt       <= '0;
            out       <= '0;
            spi_cs_n  <= 1'b1;
            spi_clock <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    spi_clock <= 1'b0;
                    if (load) begin
                        tx       <= in;
                        cnt      <= CW'(W - 1);
                        spi_cs_n <= 1'b0;
                    end else begin
                        spi_cs_n <= 1'b1;
                    end
                end
                LOW: begin
                    // MISO is captured on the same edge that raises SCLK.
                    spi_clock <= 1'b1;
                    rx        <= {rx[W-2:0], spi_miso};
                end
                HIGH: begin
                    spi_clock <= 1'b0;
                    tx        <= {tx[W-2:0], 1'b0};
                    if (cnt == '0) begin
                        // rx already holds the last bit sampled in LOW.
                        out <= rx;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_bitbang_master.sv
module tb_spi_bitbang_master;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] in;
    logic         get;
    logic         empty;
    logic [W-1:0] out;
    logic         put;
    logic         spi_cs_n;
    logic         spi_clock;
    logic         spi_mosi;
    logic         spi_miso;

    spi_bitbang_master #(.W(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in        (in),
        .get       (get),
        .empty     (empty),
        .out       (out),
        .put       (put),
        .spi_cs_n  (spi_cs_n),
        .spi_clock (spi_clock),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Source model: a small ROM with a read index that restarts on reset.
    logic [7:0] src_mem [0:15];
    int         src_len   = 0;
    int         src_idx   = 0;
    logic       hold      = 1'b0;
    int         miso_mode = 0;   // 0: loopback, 1: tied high, 2: tied low

    typedef struct {
        logic [7:0] word;
        int         load_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc         = 0;
    int   get_cnt     = 0;
    int   put_cnt     = 0;
    int   cs_high_cnt = 0;
    logic prev_sclk   = 1'b0;
    logic prev_mosi   = 1'b0;
    logic mosi_bits[$];

    assign empty    = (src_idx >= src_len) || hold;
    assign in       = (src_idx < 16) ? src_mem[src_idx[3:0]] : 8'h00;
    assign spi_miso = (miso_mode == 0) ? spi_mosi : (miso_mode == 1);

    always @(posedge clock) cyc <= cyc + 1;

    // Pop from the source and record the expected received word.
    always @(posedge clock or posedge reset) begin
        exp_t e;
        if (reset) begin
            src_idx <= 0;
            sb.delete();
        end else if (get && !empty) begin
            e.word     = (miso_mode == 0) ? in : ((miso_mode == 1) ? 8'hFF : 8'h00);
            e.load_cyc = cyc + 1;
            sb.push_back(e);
            src_idx <= src_idx + 1;
        end
    end

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clock) begin
        exp_t e;
        if (get === 1'b1) get_cnt++;
        if (spi_cs_n === 1'b1) cs_high_cnt++;
        if (spi_clock === 1'b1 && prev_sclk === 1'b0) mosi_bits.push_back(spi_mosi);
        if (spi_clock === 1'b1 && !reset) begin
            checks++;
            if (spi_mosi !== prev_mosi) begin
                failures++;
                $display("FAIL mosi_stable_high: mosi=%b required=%b at cycle %0d", spi_mosi, prev_mosi, cyc);
            end
        end
        if (put === 1'b1) begin
            put_cnt++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_put: out=%02h with nothing outstanding at cycle %0d", out, cyc);
            end else begin
                e = sb.pop_front();
                if (out !== e.word) begin
                    failures++;
                    $display("FAIL put_data: out=%02h required=%02h", out, e.word);
                end
                checks++;
                if (cyc !== e.load_cyc + 16) begin
                    failures++;
                    $display("FAIL put_latency: put at cycle %0d required %0d", cyc, e.load_cyc + 16);
                end
            end
        end
        prev_sclk = spi_clock;
        prev_mosi = spi_mosi;
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_put(input int budget, output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (put === 1'b1) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL put_timeout: no put within %0d cycles", budget);
        end
    endtask

    task automatic wait_quiet(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (sb.size() == 0 && empty && spi_cs_n === 1'b1 && put !== 1'b1) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL quiet_timeout: outstanding=%0d cs_n=%b after %0d cycles", sb.size(), spi_cs_n, budget);
        end
    endtask

    task automatic test_reset();
        src_len = 0;
        hold    = 1'b0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            checks++;
            if ({spi_cs_n, spi_clock, spi_mosi, get, put} !== 5'b10000) begin
                failures++;
                $display("FAIL reset_idle: cs_n,sclk,mosi,get,put=%b required=10000", {spi_cs_n, spi_clock, spi_mosi, get, put});
            end
            checks++;
            if (out !== 8'h00) begin
                failures++;
                $display("FAIL reset_out: out=%02h required=00", out);
            end
        end
    endtask

    task automatic test_single_word();
        int   at;
        bit   ok;
        logic [7:0] w;
        w          = 8'hA5;
        src_mem[0] = w;
        src_len    = 1;
        miso_mode  = 0;
        mosi_bits.delete();
        do_reset();
        wait_put(60, at, ok);
        checks++;
        if (mosi_bits.size() != 8) begin
            failures++;
            $display("FAIL single_bitcount: sclk_rises=%0d required=8", mosi_bits.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (mosi_bits[i] !== w[7-i]) begin
                    failures++;
                    $display("FAIL single_mosi_bit%0d: mosi=%b required=%b", i, mosi_bits[i], w[7-i]);
                end
            end
        end
        checks++;
        if (ok && out !== 8'hA5) begin
            failures++;
            $display("FAIL single_out: out=%02h required=a5", out);
        end
        @(negedge clock);
        checks++;
        if (spi_cs_n !== 1'b1 || spi_clock !== 1'b0 || spi_mosi !== 1'b0) begin
            failures++;
            $display("FAIL single_cs_release: cs_n=%b sclk=%b mosi=%b required 1,0,0", spi_cs_n, spi_clock, spi_mosi);
        end
    endtask

    task automatic load_hello();
        logic [7:0] msg [0:13];
        msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
                8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};
        for (int i = 0; i < 14; i++) src_mem[i] = msg[i];
        src_len = 14;
    endtask

    task automatic test_hello_stream();
        int at;
        int prev_at;
        int base_cs;
        bit ok;
        load_hello();
        miso_mode = 0;
        hold      = 1'b0;
        do_reset();
        prev_at = 0;
        base_cs = 0;
        for (int i = 0; i < 14; i++) begin
            wait_put(80, at, ok);
            if (!ok) break;
            if (i == 0) begin
                base_cs = cs_high_cnt;
                checks++;
                if (out !== 8'h48) begin
                    failures++;
                    $display("FAIL hello_first: out=%02h required=48", out);
                end
            end else begin
                checks++;
                if (at - prev_at != 17) begin
                    failures++;
                    $display("FAIL hello_period: put spacing=%0d required=17", at - prev_at);
                end
            end
            prev_at = at;
        end
        checks++;
        if (cs_high_cnt != base_cs) begin
            failures++;
            $display("FAIL hello_cs_low: cs high for %0d cycles mid-stream required 0", cs_high_cnt - base_cs);
        end
        @(negedge clock);
        checks++;
        if (spi_cs_n !== 1'b1) begin
            failures++;
            $display("FAIL hello_cs_end: cs_n=%b required=1", spi_cs_n);
        end
    endtask

    task automatic test_miso_tied();
        int at;
        bit ok;
        src_mem[0] = 8'h00;
        src_len    = 1;
        miso_mode  = 1;
        do_reset();
        wait_put(60, at, ok);
        checks++;
        if (ok && out !== 8'hFF) begin
            failures++;
            $display("FAIL tied_high: out=%02h required=ff", out);
        end
        wait_quiet(20);
        src_mem[0] = 8'hFF;
        miso_mode  = 2;
        do_reset();
        wait_put(60, at, ok);
        checks++;
        if (ok && out !== 8'h00) begin
            failures++;
            $display("FAIL tied_low: out=%02h required=00", out);
        end
        wait_quiet(20);
        miso_mode = 0;
    endtask

    task automatic test_reset_mid_word();
        int at;
        bit ok;
        bit reached;
        load_hello();
        miso_mode = 0;
        mosi_bits.delete();
        do_reset();
        reached = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (mosi_bits.size() >= 4) begin
                reached = 1'b1;
                break;
            end
        end
        checks++;
        if (!reached) begin
            failures++;
            $display("FAIL abort_setup: only %0d sclk rises seen", mosi_bits.size());
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (spi_cs_n !== 1'b1 || spi_clock !== 1'b0) begin
            failures++;
            $display("FAIL abort_async: cs_n=%b sclk=%b required 1,0", spi_cs_n, spi_clock);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (put !== 1'b0 || spi_cs_n !== 1'b1) begin
                failures++;
                $display("FAIL abort_hold: put=%b cs_n=%b required 0,1", put, spi_cs_n);
            end
        end
        reset = 1'b0;
        wait_put(80, at, ok);
        checks++;
        if (ok && out !== 8'h48) begin
            failures++;
            $display("FAIL abort_restart: out=%02h required=48", out);
        end
        wait_quiet(14 * 17 + 40);
    endtask

    task automatic test_empty_toggle();
        src_mem[0] = 8'h3C;
        src_mem[1] = 8'hC3;
        src_mem[2] = 8'h81;
        src_len    = 3;
        miso_mode  = 0;
        hold       = 1'b1;
        do_reset();
        @(posedge clock);
        #1;
        get_cnt = 0;
        put_cnt = 0;
        hold    = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(posedge clock);
            #1 hold = 1'($urandom_range(0, 1));
        end
        @(posedge clock);
        #1 hold = 1'b0;
        wait_quiet(200);
        checks++;
        if (get_cnt != 3) begin
            failures++;
            $display("FAIL toggle_gets: get pulses=%0d required=3", get_cnt);
        end
        checks++;
        if (put_cnt != 3) begin
            failures++;
            $display("FAIL toggle_puts: put pulses=%0d required=3", put_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_hello_stream();
        test_miso_tied();
        test_reset_mid_word();
        test_empty_toggle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
